apb_master_ctrl: RTL and testbench

APB master-side controller of the AHB-to-APB bridge. It sits between the AHB-side transfer decoder (upstream) and the APB slave peripherals (downstream). It buffers decoded transfer requests in a 2-entry queue and runs the APB SETUP/ACCESS protocol. It decodes a one-hot PSEL from the address, handles wait states and PSLVERR, and aborts stalled transfers on a timeout. Each completed transfer returns one response (read data and error flag) to the AHB side.

---
 rtl/ahb2apb_pkg.sv | 30 +++
 rtl/apb_req_fifo.sv | 62 ++++++
 rtl/apb_master_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_apb_master_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb2apb_pkg.sv
// Shared types and helpers for the AHB-to-APB bridge master side:
// FSM state encoding, the queued request record and the slave-select decoder.
package ahb2apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int MAX_SLV    = 256;
  localparam int SEL_MAX_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic                  write;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

  // Returns a one-hot vector with bit 'sel' set; callers keep the low NUM_SLV bits.
  function automatic logic [MAX_SLV-1:0] slv_decode(input logic [SEL_MAX_W-1:0] sel);
    logic [MAX_SLV-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/apb_req_fifo.sv
// Two-entry synchronous FIFO holding decoded transfer requests between the
// AHB-side decoder and the APB master FSM; synchronous active-low reset.
module apb_req_fifo
  import ahb2apb_pkg::*;
#(
  parameter type entry_t = apb_req_t
) (
  input  logic       hclk,
  input  logic       hresetn,
  input  logic       push_i,
  input  entry_t     push_data_i,
  input  logic       pop_i,
  output entry_t     pop_data_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [1:0] count_o
);

  entry_t     mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push_s;
  logic       do_pop_s;

  always_comb begin
    do_push_s  = push_i && (count_q != 2'd2);
    do_pop_s   = pop_i && (count_q != 2'd0);
    full_o     = (count_q == 2'd2);
    empty_o    = (count_q == 2'd0);
    count_o    = count_q;
    pop_data_o = mem_q[rd_ptr_q];
  end

  // Storage carries no reset; only pointers and occupancy define validity.
  always_ff @(posedge hclk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master controller of the AHB-to-APB bridge: queues requests, runs the
// SETUP/ACCESS protocol with wait states, PSLVERR and timeout, returns one response per transfer.
module apb_master_ctrl
  import ahb2apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int NUM_SLV     = 4,
  parameter int SLV_SEL_LSB = 28,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic               req_write,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               rsp_err,
  output logic [NUM_SLV-1:0] psel,
  output logic               penable,
  output logic [ADDR_W-1:0]  paddr,
  output logic               pwrite,
  output logic [DATA_W-1:0]  pwdata,
  input  logic [DATA_W-1:0]  prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int SEL_W  = $clog2(NUM_SLV);
  localparam int WAIT_W = $clog2(TIMEOUT_CYC) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
  } req_t;

  apb_state_e         state_q;
  logic [NUM_SLV-1:0] psel_q;
  logic               penable_q;
  logic [ADDR_W-1:0]  paddr_q;
  logic               pwrite_q;
  logic [DATA_W-1:0]  pwdata_q;
  logic [WAIT_W-1:0]  wait_q;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic               rsp_err_q;
  logic               rst_done_q;

  req_t               push_data_s;
  req_t               head_s;
  logic               push_s;
  logic               pop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic [1:0]         fifo_count_s;
  logic [SEL_MAX_W-1:0] sel_s;
  logic [MAX_SLV-1:0] sel_oh_s;
  logic [NUM_SLV-1:0] psel_d;
  logic               timeout_s;
  logic               done_s;
  logic               rsp_err_d;
  logic [DATA_W-1:0]  rsp_rdata_d;

  apb_req_fifo #(
    .entry_t (req_t)
  ) u_req_fifo (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .push_i      (push_s),
    .push_data_i (push_data_s),
    .pop_i       (pop_s),
    .pop_data_o  (head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_s)
  );

  // req_ready is held low until the first edge after reset release.
  always_comb begin
    req_ready         = rst_done_q && (fifo_count_s < 2'd2);
    push_s            = req_valid && req_ready && !fifo_full_s;
    push_data_s.addr  = req_addr;
    push_data_s.write = req_write;
    push_data_s.wdata = req_wdata;
  end

  always_comb begin
    sel_s              = '0;
    sel_s[SEL_W-1:0]   = head_s.addr[SLV_SEL_LSB +: SEL_W];
    sel_oh_s           = slv_decode(sel_s);
    psel_d             = sel_oh_s[NUM_SLV-1:0];
    timeout_s          = (state_q == ACCESS) && !pready &&
                         (wait_q == WAIT_W'(TIMEOUT_CYC - 1));
    done_s             = (state_q == ACCESS) && (pready || timeout_s);
    pop_s              = !fifo_empty_s && ((state_q == IDLE) || done_s);
    // A timeout completes with an error; pready on the same edge wins.
    rsp_err_d          = done_s && (!pready || pslverr);
    if (done_s && pready && !pslverr && !pwrite_q) begin
      rsp_rdata_d = prdata;
    end else begin
      rsp_rdata_d = '0;
    end
  end

  // Protocol FSM with all APB and response outputs registered.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      wait_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rst_done_q  <= 1'b0;
    end else begin
      rst_done_q  <= 1'b1;
      rsp_valid_q <= done_s;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      case (state_q)
        IDLE: begin
          if (pop_s) begin
            state_q   <= SETUP;
            psel_q    <= psel_d;
            penable_q <= 1'b0;
            paddr_q   <= head_s.addr;
            pwrite_q  <= head_s.write;
            pwdata_q  <= head_s.wdata;
          end else begin
            psel_q    <= '0;
            penable_q <= 1'b0;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
          wait_q    <= '0;
        end
        ACCESS: begin
          if (done_s && pop_s) begin
            state_q   <= SETUP;
            psel_q    <= psel_d;
            penable_q <= 1'b0;
            paddr_q   <= head_s.addr;
            pwrite_q  <= head_s.write;
            pwdata_q  <= head_s.wdata;
          end else if (done_s) begin
            state_q   <= IDLE;
            psel_q    <= '0;
            penable_q <= 1'b0;
          end else begin
            wait_q    <= wait_q + WAIT_W'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= '0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    psel      = psel_q;
    penable   = penable_q;
    paddr     = paddr_q;
    pwrite    = pwrite_q;
    pwdata    = pwdata_q;
    rsp_valid = rsp_valid_q;
    rsp_rdata = rsp_rdata_q;
    rsp_err   = rsp_err_q;
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: a behavioural APB slave, a response
// scoreboard queue and a monitor that checks every rsp_valid pulse.
module tb_apb_master_ctrl;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  apb_master_ctrl dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          wait_cfg = 0;
  logic        err_cfg = 1'b0;
  logic        use_addr = 1'b0;
  logic [31:0] prdata_cfg = 32'h0;
  int          acc_cnt = 0;
  logic        mon_en = 1'b0;
  localparam logic [31:0] RD_XOR = 32'hFFFF_0000;

  always @(posedge hclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge hclk);
  endtask

  // Caller is at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d, output int hs);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_wdata = d;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge hclk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout addr %h", a);
    end
    hs = cyc;
    @(negedge hclk);
  endtask

  function automatic logic [3:0] dec(input logic [31:0] a);
    logic [3:0] one;
    one = 4'b0001;
    return one << a[29:28];
  endfunction

  // Behavioural APB slave: inserts wait_cfg wait states per ACCESS phase.
  initial begin
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    forever begin
      @(negedge hclk);
      if (psel !== 4'b0000 && penable === 1'b1) acc_cnt++;
      else acc_cnt = 0;
      pready  = (acc_cnt > wait_cfg);
      pslverr = pready && err_cfg;
      prdata  = pready ? (use_addr ? (paddr ^ RD_XOR) : prdata_cfg) : 32'h0;
    end
  end

  // Response monitor / scoreboard.
  initial begin
    forever begin
      @(negedge hclk);
      if (mon_en) begin
        if (rsp_valid === 1'b1) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp at cycle %0d rdata %h err %b", cyc, rsp_rdata, rsp_err);
          end else begin
            mon_e = sb_q.pop_front();
            chk("rsp_rdata", rsp_rdata, mon_e.rdata);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
            chk("rsp_cycle", cyc, mon_e.cyc);
          end
        end else begin
          chk("rsp_idle", {rsp_err, rsp_rdata[30:0]}, 32'h0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int h, h2, h3;
    logic ok;
    hresetn = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_write = 1'b0; req_wdata = 32'h0;
    repeat (3) @(negedge hclk);
    chk("reset_psel", {28'b0, psel}, 32'h0);
    chk("reset_penable", {31'b0, penable}, 32'h0);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("reset_req_ready", {31'b0, req_ready}, 32'h0);
    chk("reset_paddr", paddr, 32'h0);
    chk("reset_pwdata", pwdata, 32'h0);
    hresetn = 1'b1;
    @(negedge hclk);
    chk("ready_after_reset", {31'b0, req_ready}, 32'h1);
    mon_en = 1'b1;

    // Single read, zero wait states.
    wait_cfg = 0; prdata_cfg = 32'h0000_00A5;
    send(32'h1000_0004, 1'b0, 32'h0, h);
    req_valid = 1'b0;
    sb_q.push_back('{32'h0000_00A5, 1'b0, h + 4});
    chk("t1_c1_psel", {28'b0, psel}, 32'h0);
    wait_cyc(h + 2);
    chk("t1_setup_psel", {28'b0, psel}, 32'h2);
    chk("t1_setup_penable", {31'b0, penable}, 32'h0);
    chk("t1_setup_paddr", paddr, 32'h1000_0004);
    wait_cyc(h + 3);
    chk("t1_access_penable", {31'b0, penable}, 32'h1);
    wait_cyc(h + 6);

    // Write with three wait states.
    wait_cfg = 3;
    send(32'h3000_0010, 1'b1, 32'hDEAD_BEEF, h);
    req_valid = 1'b0;
    sb_q.push_back('{32'h0, 1'b0, h + 7});
    wait_cyc(h + 2);
    chk("t2_psel", {28'b0, psel}, 32'h8);
    chk("t2_pwrite", {31'b0, pwrite}, 32'h1);
    for (int k = 3; k <= 6; k++) begin
      wait_cyc(h + k);
      chk("t2_access_penable", {31'b0, penable}, 32'h1);
      chk("t2_pwdata", pwdata, 32'hDEAD_BEEF);
      chk("t2_paddr", paddr, 32'h3000_0010);
    end
    wait_cyc(h + 7);
    chk("t2_idle_psel", {28'b0, psel}, 32'h0);
    chk("t2_idle_hold_paddr", paddr, 32'h3000_0010);
    wait_cyc(h + 9);

    // Three back-to-back reads, req_valid held high.
    wait_cfg = 0; use_addr = 1'b1;
    send(32'h0000_0100, 1'b0, 32'h0, h);
    send(32'h1000_0200, 1'b0, 32'h0, h2);
    send(32'h2000_0300, 1'b0, 32'h0, h3);
    req_valid = 1'b0;
    chk("t3_hs_spacing", h3 - h, 32'd2);
    chk("t3_ready_low", {31'b0, req_ready}, 32'h0);
    sb_q.push_back('{32'h0000_0100 ^ RD_XOR, 1'b0, h + 4});
    sb_q.push_back('{32'h1000_0200 ^ RD_XOR, 1'b0, h + 6});
    sb_q.push_back('{32'h2000_0300 ^ RD_XOR, 1'b0, h + 8});
    wait_cyc(h + 4);
    chk("t3_setup2_psel", {28'b0, psel}, {28'b0, dec(32'h1000_0200)});
    chk("t3_setup2_penable", {31'b0, penable}, 32'h0);
    chk("t3_setup2_paddr", paddr, 32'h1000_0200);
    wait_cyc(h + 6);
    chk("t3_setup3_psel", {28'b0, psel}, {28'b0, dec(32'h2000_0300)});
    chk("t3_setup3_penable", {31'b0, penable}, 32'h0);
    wait_cyc(h + 10);
    use_addr = 1'b0;

    // Read answered with PSLVERR.
    err_cfg = 1'b1; prdata_cfg = 32'h1234_5678;
    send(32'h2000_0000, 1'b0, 32'h0, h);
    req_valid = 1'b0;
    sb_q.push_back('{32'h0, 1'b1, h + 4});
    wait_cyc(h + 6);
    err_cfg = 1'b0;

    // Timeout: pready never rises.
    wait_cfg = 1000;
    send(32'h0000_0040, 1'b0, 32'h0, h);
    req_valid = 1'b0;
    sb_q.push_back('{32'h0, 1'b1, h + 19});
    wait_cyc(h + 18);
    chk("t5_access16_penable", {31'b0, penable}, 32'h1);
    wait_cyc(h + 19);
    chk("t5_idle_psel", {28'b0, psel}, 32'h0);
    chk("t5_idle_penable", {31'b0, penable}, 32'h0);
    wait_cyc(h + 21);

    // pready on the 16th ACCESS cycle wins over the timeout.
    wait_cfg = 15; prdata_cfg = 32'hCAFE_0001;
    send(32'h1000_0080, 1'b0, 32'h0, h);
    req_valid = 1'b0;
    sb_q.push_back('{32'hCAFE_0001, 1'b0, h + 19});
    wait_cyc(h + 21);

    // Reset during ACCESS with one request still queued.
    wait_cfg = 1000;
    send(32'h0000_0100, 1'b0, 32'h0, h);
    send(32'h1000_0100, 1'b0, 32'h0, h2);
    req_valid = 1'b0;
    wait_cyc(h + 5);
    chk("t6_in_access", {31'b0, penable}, 32'h1);
    hresetn = 1'b0;
    @(negedge hclk);
    chk("t6_rst_psel", {28'b0, psel}, 32'h0);
    chk("t6_rst_penable", {31'b0, penable}, 32'h0);
    chk("t6_rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("t6_rst_req_ready", {31'b0, req_ready}, 32'h0);
    hresetn = 1'b1;
    @(negedge hclk);
    chk("t6_rel_req_ready", {31'b0, req_ready}, 32'h1);
    ok = 1'b1;
    repeat (8) begin
      @(negedge hclk);
      if (psel !== 4'b0000 || penable !== 1'b0) ok = 1'b0;
    end
    chk("t6_no_reissue", {31'b0, ok}, 32'h1);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
